// File: rtl/cluster_bus_ot_limiter.sv
// Outstanding-transaction limiter and drain controller for one crossbar slave port.
// Define CLUSTER_BUS_OT_STATS_EN to add saturating AR/AW stall-cycle counters.
module cluster_bus_ot_limiter #(
    parameter int MAX_RD_OT = 8,
    parameter int MAX_WR_OT = 8,
    parameter int RD_CNT_W  = $clog2(MAX_RD_OT + 1),
    parameter int WR_CNT_W  = $clog2(MAX_WR_OT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [RD_CNT_W-1:0] rd_limit_i,
    input  logic [WR_CNT_W-1:0] wr_limit_i,
    input  logic                drain_req_i,
    output logic                drain_ack_o,
    input  logic                slv_ar_valid_i,
    output logic                slv_ar_ready_o,
    output logic                mst_ar_valid_o,
    input  logic                mst_ar_ready_i,
    input  logic                slv_aw_valid_i,
    output logic                slv_aw_ready_o,
    output logic                mst_aw_valid_o,
    input  logic                mst_aw_ready_i,
    input  logic                r_valid_i,
    input  logic                r_ready_i,
    input  logic                r_last_i,
    input  logic                b_valid_i,
    input  logic                b_ready_i,
    output logic [RD_CNT_W-1:0] rd_ot_o,
    output logic [WR_CNT_W-1:0] wr_ot_o,
`ifdef CLUSTER_BUS_OT_STATS_EN
    input  logic                stats_clr_i,
    output logic [31:0]         ar_stall_cnt_o,
    output logic [31:0]         aw_stall_cnt_o,
`endif
    output logic                err_o
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DRAINED
    } state_t;

    localparam logic [RD_CNT_W-1:0] RD_MAX = RD_CNT_W'(MAX_RD_OT);
    localparam logic [WR_CNT_W-1:0] WR_MAX = WR_CNT_W'(MAX_WR_OT);

    state_t              state_q, state_d;
    logic [RD_CNT_W-1:0] rd_ot_q, rd_ot_d;
    logic [WR_CNT_W-1:0] wr_ot_q, wr_ot_d;
    logic                ar_fwd_q, aw_fwd_q;
    logic                err_q;
    logic                rd_err, wr_err;
    logic [RD_CNT_W-1:0] eff_rd_limit;
    logic [WR_CNT_W-1:0] eff_wr_limit;
    logic                allow_ar, allow_aw;
    logic                ar_hs, aw_hs, r_ret, b_ret;
    logic                idle_nxt;

    assign eff_rd_limit = (rd_limit_i > RD_MAX) ? RD_MAX : rd_limit_i;
    assign eff_wr_limit = (wr_limit_i > WR_MAX) ? WR_MAX : wr_limit_i;

    // A request already presented downstream keeps its permission until accepted.
    assign allow_ar = ar_fwd_q | ((state_q == RUN) & (rd_ot_q < eff_rd_limit));
    assign allow_aw = aw_fwd_q | ((state_q == RUN) & (wr_ot_q < eff_wr_limit));

    assign mst_ar_valid_o = slv_ar_valid_i & allow_ar;
    assign slv_ar_ready_o = mst_ar_ready_i & allow_ar;
    assign mst_aw_valid_o = slv_aw_valid_i & allow_aw;
    assign slv_aw_ready_o = mst_aw_ready_i & allow_aw;

    assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
    assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
    assign r_ret = r_valid_i & r_ready_i & r_last_i;
    assign b_ret = b_valid_i & b_ready_i;

    always_comb begin
        rd_ot_d = rd_ot_q;
        rd_err  = 1'b0;
        unique case ({ar_hs, r_ret})
            2'b10: rd_ot_d = rd_ot_q + RD_CNT_W'(1);
            2'b01: begin
                if (rd_ot_q == '0) rd_err = 1'b1;
                else rd_ot_d = rd_ot_q - RD_CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ot_d = wr_ot_q;
        wr_err  = 1'b0;
        unique case ({aw_hs, b_ret})
            2'b10: wr_ot_d = wr_ot_q + WR_CNT_W'(1);
            2'b01: begin
                if (wr_ot_q == '0) wr_err = 1'b1;
                else wr_ot_d = wr_ot_q - WR_CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Quiescent once both counts land at zero with nothing left on AR/AW.
    assign idle_nxt = (rd_ot_d == '0) & (wr_ot_d == '0) &
                      ~mst_ar_valid_o & ~mst_aw_valid_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (drain_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req_i) state_d = RUN;
                else if (idle_nxt) state_d = DRAINED;
            end
            DRAINED: begin
                if (!drain_req_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            rd_ot_q  <= '0;
            wr_ot_q  <= '0;
            ar_fwd_q <= 1'b0;
            aw_fwd_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ot_q  <= rd_ot_d;
            wr_ot_q  <= wr_ot_d;
            ar_fwd_q <= mst_ar_valid_o & ~mst_ar_ready_i;
            aw_fwd_q <= mst_aw_valid_o & ~mst_aw_ready_i;
            err_q    <= err_q | rd_err | wr_err;
        end
    end

    assign drain_ack_o = (state_q == DRAINED);
    assign rd_ot_o     = rd_ot_q;
    assign wr_ot_o     = wr_ot_q;
    assign err_o       = err_q;

`ifdef CLUSTER_BUS_OT_STATS_EN
    logic [31:0] ar_stall_q, aw_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_stall_q <= '0;
            aw_stall_q <= '0;
        end else if (stats_clr_i) begin
            ar_stall_q <= '0;
            aw_stall_q <= '0;
        end else begin
            if (slv_ar_valid_i && !allow_ar && ar_stall_q != '1)
                ar_stall_q <= ar_stall_q + 32'd1;
            if (slv_aw_valid_i && !allow_aw && aw_stall_q != '1)
                aw_stall_q <= aw_stall_q + 32'd1;
        end
    end

    assign ar_stall_cnt_o = ar_stall_q;
    assign aw_stall_cnt_o = aw_stall_q;
`else
    // no stall statistics in this build
`endif

endmodule

// File: tb/tb_cluster_bus_ot_limiter.sv
// Directed plus random bench for cluster_bus_ot_limiter against a count-level model.
// Stall counters are checked when CLUSTER_BUS_OT_STATS_EN is defined.
module tb_cluster_bus_ot_limiter;

    localparam int MAX_RD = 8;
    localparam int MAX_WR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rd_limit, wr_limit;
    logic       drain_req, drain_ack;
    logic       arv, slv_arr, mst_arv, mst_arr;
    logic       awv, slv_awr, mst_awv, mst_awr;
    logic       rv, rr, rl, bv, br;
    logic [3:0] rd_ot, wr_ot;
    logic       err;
`ifdef CLUSTER_BUS_OT_STATS_EN
    logic        stats_clr;
    logic [31:0] ar_stall, aw_stall;
    logic [31:0] m_ars, m_aws;
`endif

    cluster_bus_ot_limiter #(.MAX_RD_OT(MAX_RD), .MAX_WR_OT(MAX_WR)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rd_limit_i(rd_limit),
        .wr_limit_i(wr_limit),
        .drain_req_i(drain_req),
        .drain_ack_o(drain_ack),
        .slv_ar_valid_i(arv),
        .slv_ar_ready_o(slv_arr),
        .mst_ar_valid_o(mst_arv),
        .mst_ar_ready_i(mst_arr),
        .slv_aw_valid_i(awv),
        .slv_aw_ready_o(slv_awr),
        .mst_aw_valid_o(mst_awv),
        .mst_aw_ready_i(mst_awr),
        .r_valid_i(rv),
        .r_ready_i(rr),
        .r_last_i(rl),
        .b_valid_i(bv),
        .b_ready_i(br),
        .rd_ot_o(rd_ot),
        .wr_ot_o(wr_ot),
`ifdef CLUSTER_BUS_OT_STATS_EN
        .stats_clr_i(stats_clr),
        .ar_stall_cnt_o(ar_stall),
        .aw_stall_cnt_o(aw_stall),
`endif
        .err_o(err)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // model: outstanding counts, pending forwarded requests, drain view
    int m_rd, m_wr;
    bit m_err, m_ack, m_blk, m_fwd_ar, m_fwd_aw;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lim(input logic [3:0] l, input int mx);
        return (int'(l) > mx) ? mx : int'(l);
    endfunction

    task automatic reset_model();
        m_rd = 0; m_wr = 0;
        m_err = 0; m_ack = 0; m_blk = 0;
        m_fwd_ar = 0; m_fwd_aw = 0;
`ifdef CLUSTER_BUS_OT_STATS_EN
        m_ars = 0; m_aws = 0;
`endif
    endtask

    task automatic idle();
        arv = 0; awv = 0; rv = 0; rr = 0; rl = 0; bv = 0; br = 0;
    endtask

    // one clock cycle: inputs already driven just after a falling edge
    task automatic step();
        bit al_ar, al_aw, e_arv, e_awv, hs_ar, hs_aw, ret_r, ret_b;
        #1;
        al_ar = m_fwd_ar || (!m_blk && m_rd < lim(rd_limit, MAX_RD));
        al_aw = m_fwd_aw || (!m_blk && m_wr < lim(wr_limit, MAX_WR));
        e_arv = arv && al_ar;
        e_awv = awv && al_aw;
        check("mst_ar_valid", 32'(mst_arv), 32'(e_arv));
        check("slv_ar_ready", 32'(slv_arr), 32'(mst_arr && al_ar));
        check("mst_aw_valid", 32'(mst_awv), 32'(e_awv));
        check("slv_aw_ready", 32'(slv_awr), 32'(mst_awr && al_aw));
        hs_ar = e_arv && mst_arr;
        hs_aw = e_awv && mst_awr;
        ret_r = rv && rr && rl;
        ret_b = bv && br;
        @(posedge clk);
        if (hs_ar && !ret_r) m_rd++;
        else if (ret_r && !hs_ar) begin
            if (m_rd == 0) m_err = 1; else m_rd--;
        end
        if (hs_aw && !ret_b) m_wr++;
        else if (ret_b && !hs_aw) begin
            if (m_wr == 0) m_err = 1; else m_wr--;
        end
        m_fwd_ar = e_arv && !mst_arr;
        m_fwd_aw = e_awv && !mst_awr;
        m_ack = drain_req && m_blk &&
                (m_ack || (m_rd == 0 && m_wr == 0 && !e_arv && !e_awv));
        m_blk = drain_req;
`ifdef CLUSTER_BUS_OT_STATS_EN
        if (stats_clr) begin
            m_ars = 0; m_aws = 0;
        end else begin
            if (arv && !al_ar && m_ars != 32'hFFFF_FFFF) m_ars++;
            if (awv && !al_aw && m_aws != 32'hFFFF_FFFF) m_aws++;
        end
`endif
        #1;
        check("rd_ot", 32'(rd_ot), 32'(m_rd));
        check("wr_ot", 32'(wr_ot), 32'(m_wr));
        check("err", 32'(err), 32'(m_err));
        check("drain_ack", 32'(drain_ack), 32'(m_ack));
`ifdef CLUSTER_BUS_OT_STATS_EN
        check("ar_stall", ar_stall, m_ars);
        check("aw_stall", aw_stall, m_aws);
`endif
        @(negedge clk);
    endtask

    initial begin
        rst = 1; rd_limit = 8; wr_limit = 8; drain_req = 0;
        mst_arr = 0; mst_awr = 0;
        idle();
`ifdef CLUSTER_BUS_OT_STATS_EN
        stats_clr = 0;
`endif
        reset_model();
        @(negedge clk);
        check("rst_rd_ot", 32'(rd_ot), 0);
        check("rst_wr_ot", 32'(wr_ot), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ack", 32'(drain_ack), 0);
        rst = 0;

        // read limit 2 with four back-to-back requests
        rd_limit = 2; arv = 1; mst_arr = 1;
        repeat (4) step();
        check("tp1_rd_ot", 32'(rd_ot), 2);
        check("tp1_blocked", 32'(slv_arr), 0);
        rv = 1; rr = 1; rl = 1;
        step();
        rv = 0; rr = 0; rl = 0;
        #1 check("tp1_third_ar", 32'(mst_arv), 1);
        step();
        check("tp1_after", 32'(rd_ot), 2);
        arv = 0; rv = 1; rr = 1; rl = 1;
        repeat (2) step();
        idle();

        // simultaneous issue and retire
        rd_limit = 8; arv = 1;
        repeat (3) step();
        rv = 1; rr = 1; rl = 1;
        step();
        check("tp2_rd_same", 32'(rd_ot), 3);
        arv = 0;
        repeat (3) step();
        idle();
        awv = 1; mst_awr = 1;
        step();
        bv = 1; br = 1;
        step();
        check("tp2_wr_same", 32'(wr_ot), 1);
        awv = 0;
        step();
        idle();

        // drain with three writes in flight
        awv = 1;
        repeat (3) step();
        awv = 0; drain_req = 1;
        step();
        awv = 1;
        #1 check("tp3_aw_blocked", 32'(mst_awv), 0);
        bv = 1; br = 1;
        repeat (2) step();
        check("tp3_ack_early", 32'(drain_ack), 0);
        step();
        check("tp3_ack", 32'(drain_ack), 1);
        bv = 0; br = 0; drain_req = 0;
        step();
        check("tp3_ack_low", 32'(drain_ack), 0);
        check("tp3_aw_open", 32'(mst_awv), 1);
        step();
        awv = 0; bv = 1; br = 1;
        step();
        idle();

        // limit clamp and zero limit
        rd_limit = 15; arv = 1;
        repeat (12) step();
        check("tp4_clamp", 32'(rd_ot), 8);
        arv = 0; rv = 1; rr = 1; rl = 1;
        repeat (8) step();
        idle();
        rd_limit = 0; arv = 1;
        repeat (3) step();
        check("tp4_zero_fwd", 32'(mst_arv), 0);
        check("tp4_zero_err", 32'(err), 0);
        idle();

        // stray retire, then asynchronous reset mid-burst
        rv = 1; rr = 1; rl = 1;
        step();
        check("tp5_err", 32'(err), 1);
        check("tp5_rd_zero", 32'(rd_ot), 0);
        idle();
        rd_limit = 8; arv = 1;
        repeat (5) step();
        check("tp5_rd5", 32'(rd_ot), 5);
        #3 rst = 1;
        #1;
        check("tp5_rst_rd", 32'(rd_ot), 0);
        check("tp5_rst_wr", 32'(wr_ot), 0);
        check("tp5_rst_err", 32'(err), 0);
        check("tp5_rst_ack", 32'(drain_ack), 0);
        reset_model();
        idle();
        @(negedge clk);
        rst = 0;

`ifdef CLUSTER_BUS_OT_STATS_EN
        rd_limit = 1; arv = 1;
        step();
        stats_clr = 1;
        step();
        stats_clr = 0;
        check("tp6_clr0", ar_stall, 0);
        repeat (10) step();
        check("tp6_stall10", ar_stall, 10);
        stats_clr = 1;
        step();
        stats_clr = 0;
        check("tp6_clr", ar_stall, 0);
        arv = 0; rv = 1; rr = 1; rl = 1;
        step();
        idle();
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                rd_limit = 4'($urandom_range(0, 10));
                wr_limit = 4'($urandom_range(0, 10));
            end
            if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
            arv = 1'($urandom_range(0, 1));
            awv = 1'($urandom_range(0, 1));
            mst_arr = 1'($urandom_range(0, 1));
            mst_awr = 1'($urandom_range(0, 1));
            rv = (m_rd > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
            rr = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            bv = (m_wr > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
            br = 1'($urandom_range(0, 1));
`ifdef CLUSTER_BUS_OT_STATS_EN
            stats_clr = ($urandom_range(0, 50) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cluster_bus_ot_limiter.md
Name: cluster_bus_ot_limiter

Overview:
- Per-slave-port outstanding-transaction (OT) regulator and drain controller, placed between one initiator (data, instr, DMA or ext) and its slave port on the cluster AXI crossbar.
- Counts in-flight reads and writes from the AR/AW/R/B handshakes.
- Gates AR/AW valid/ready when a software-programmable OT limit is reached.
- Provides a drain handshake so the cluster controller can quiesce the port before clock gating or a cluster_id / address-map change.

Parameters:
- MAX_RD_OT, 8, hardware ceiling on outstanding reads; sizes the counters.
- MAX_WR_OT, 8, hardware ceiling on outstanding writes; sizes the counters.
- RD_CNT_W, $clog2(MAX_RD_OT+1), read counter / limit width (derived, do not override).
- WR_CNT_W, $clog2(MAX_WR_OT+1), write counter / limit width (derived, do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- rd_limit_i  in  RD_CNT_W  programmed read OT limit; values >MAX_RD_OT clamp to MAX_RD_OT.
- wr_limit_i  in  WR_CNT_W  programmed write OT limit; same clamping rule.
- drain_req_i  in  1  level request to quiesce the port.
- drain_ack_o  out  1  port blocked and no transactions outstanding.
- slv_ar_valid_i  in  1  AR valid from initiator.
- slv_ar_ready_o  out  1  AR ready to initiator.
- mst_ar_valid_o  out  1  AR valid to crossbar.
- mst_ar_ready_i  in  1  AR ready from crossbar.
- slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i  in/out/out/in  1 each  same scheme for AW.
- r_valid_i, r_ready_i, r_last_i  in  1 each  R channel snoop (not gated).
- b_valid_i, b_ready_i  in  1 each  B channel snoop (not gated).
- rd_ot_o  out  RD_CNT_W  current outstanding reads.
- wr_ot_o  out  WR_CNT_W  current outstanding writes.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_i=1):
  - rd_ot_o=0, wr_ot_o=0, err_o=0, drain_ack_o=0, state=RUN.
  - Gating outputs are driven from the reset-state values.
- Gating (combinational, zero added latency):
  - allow_ar = (state==RUN) & (rd_ot < eff_rd_limit).
  - mst_ar_valid_o = slv_ar_valid_i & allow_ar.
  - slv_ar_ready_o = mst_ar_ready_i & allow_ar.
  - AW uses the same scheme with wr_ot and eff_wr_limit.
  - No combinational path from slv_*_valid_i to slv_*_ready_o.
- Counting:
  - AR handshake = mst_ar_valid_o & mst_ar_ready_i; it increments rd_ot.
  - Read retire = r_valid_i & r_ready_i & r_last_i; it decrements rd_ot.
  - Simultaneous AR handshake and read retire: rd_ot unchanged.
  - Write side: AW handshake increments, B handshake decrements.
  - Counters update on the clk_i edge following the handshake cycle.
- Limits:
  - eff_limit = min(limit_i, MAX).
  - Limit 0 blocks all new requests.
  - Limits are sampled live. Lowering a limit below the current count never drops traffic; it only blocks new requests until the count falls below it.
  - Once an AX valid is forwarded it stays forwarded until its handshake completes. A limit decrease while mst_*_valid_o=1 without ready is honoured only after that handshake (a registered "forwarding" flag holds allow).
- Errors:
  - Decrement with counter==0 (stray retire) leaves the counter at 0 and sets err_o.
  - Increment at MAX is impossible by construction.
  - err_o is cleared only by reset.
- FSM states: RUN, DRAIN, DRAINED.
  - RUN -> DRAIN when drain_req_i=1. New AX is blocked from the next cycle, except an AX already being forwarded, which completes.
  - DRAIN -> DRAINED when rd_ot==0 and wr_ot==0 and no AX is forwarding. drain_ack_o=1 from that cycle (registered).
  - DRAIN or DRAINED -> RUN when drain_req_i=0. drain_ack_o deasserts in the same edge, and traffic is allowed the following cycle.
  - drain_req_i asserted with counters already 0: RUN -> DRAIN -> DRAINED, so drain_ack_o rises 2 cycles after the request.
- Reset mid-operation: counters, FSM and err_o clear immediately. The crossbar is reset together with this block, so no retire is expected afterwards.

Optional Feature:
- Macro CLUSTER_BUS_OT_STATS_EN.
- When defined, the block adds:
  - ar_stall_cnt_o [31:0] and aw_stall_cnt_o [31:0].
  - Each counts cycles where slv_*_valid_i=1 and allow_*=0 (limit or drain stall).
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
  - Input stats_clr_i [1] clears both counters synchronously; clear takes priority over increment.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- rd_limit_i=2; initiator issues 4 back-to-back ARs with mst_ar_ready_i=1 and no R -> exactly 2 handshakes, rd_ot_o=2, slv_ar_ready_o=0 thereafter. One R with last -> 3rd AR accepted the next cycle.
- AR handshake and R-last retire in the same cycle with rd_ot=3 -> rd_ot_o stays 3; repeat on the AW/B side with wr_ot=1 -> stays 1.
- wr_ot=3, drain_req_i=1 -> AW blocked next cycle. After 3 B handshakes drain_ack_o=1 exactly 1 cycle after the last B. drain_req_i=0 -> ack low, AW accepted the next cycle.
- rd_limit_i=15 with MAX_RD_OT=8 -> at most 8 outstanding reads. rd_limit_i=0 -> no AR forwarded, err_o stays 0.
- R last with rd_ot=0 -> err_o=1 and rd_ot_o=0. Assert rst_i mid-burst with rd_ot=5 -> all outputs 0 asynchronously.
- With CLUSTER_BUS_OT_STATS_EN: limit 1, AR held valid for 10 cycles while blocked -> ar_stall_cnt_o=10. stats_clr_i pulse -> 0.
